// File: rtl/pattern_sequencer.sv
// Pattern RAM plus tempo-driven row playback feeding the tracker's note/speed inputs.
// Optional per-tick volume fade in/out effects are enabled by PATTERN_SEQ_VOLRAMP_EN.
module pattern_sequencer #(
    parameter int ROWS     = 64,
    parameter int NOTEW    = 16,
    parameter int MAXSPEED = 16,
    parameter int TICKDIV  = 1000,
    localparam int RW      = $clog2(ROWS),
    localparam int SPLEN   = $clog2(MAXSPEED)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [RW-1:0]    wr_addr,
    input  logic [NOTEW-1:0] wr_data,
    input  logic             play,
    input  logic             stop,
    input  logic             loop_en,
    input  logic [RW:0]      len,
    input  logic [3:0]       tpr,
    output logic [NOTEW-1:0] note_out,
    output logic             note_valid,
    output logic [SPLEN-1:0] speed,
    output logic [RW-1:0]    row,
    output logic             row_strobe,
    output logic             busy,
    output logic             done
);

    localparam int PW = (TICKDIV > 1) ? $clog2(TICKDIV) : 1;
    localparam logic [RW:0] ONE_W   = (RW+1)'(1);
    localparam logic [RW:0] LEN_MAX = (RW+1)'(ROWS);

    typedef enum logic [1:0] {IDLE, FETCH, PLAY} state_t;

    state_t           state_q, state_d;
    logic [NOTEW-1:0] mem [ROWS];
    logic [NOTEW-1:0] rdata_q;
    logic [RW-1:0]    rd_addr;
    logic [NOTEW-1:0] note_q, note_d;
    logic             valid_q, valid_d;
    logic [SPLEN-1:0] speed_q, speed_d;
    logic [RW-1:0]    row_q, row_d;
    logic             strobe_q, strobe_d;
    logic             done_q, done_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [3:0]       tick_q, tick_d;
    logic [3:0]       tpr_m1;
    logic             tick_end, row_end, last_row;
    logic [RW-1:0]    next_row, load_row;
    logic             load;
`ifdef PATTERN_SEQ_VOLRAMP_EN
    logic [4:0]       vol_tgt_q, vol_tgt_d;
`endif

    // Full-width product, then clamp into the tracker's step range.
    function automatic logic [SPLEN-1:0] calc_speed(input logic [NOTEW-1:0] w);
        logic [31:0] full;
        full = (32'(w[2:0]) + 32'd1) << w[5:3];
        if (w == '0) return '0;
        if (full > 32'(MAXSPEED - 1)) return SPLEN'(MAXSPEED - 1);
        return full[SPLEN-1:0];
    endfunction

    assign tpr_m1   = (tpr == 4'd0) ? 4'd0 : tpr - 4'd1;
    assign tick_end = (presc_q == PW'(TICKDIV - 1));
    assign row_end  = tick_end && (tick_q >= tpr_m1);
    assign last_row = ({1'b0, row_q} + ONE_W) >= len;
    assign next_row = last_row ? '0 : row_q + RW'(1);
    // Keep the upcoming row's word registered so it is ready at the boundary.
    assign rd_addr  = (state_q == PLAY) ? next_row : '0;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        rdata_q <= mem[rd_addr];
    end

    always_comb begin
        state_d  = state_q;
        note_d   = note_q;
        valid_d  = valid_q;
        speed_d  = speed_q;
        row_d    = row_q;
        strobe_d = 1'b0;
        done_d   = 1'b0;
        presc_d  = presc_q;
        tick_d   = tick_q;
        load     = 1'b0;
        load_row = '0;
`ifdef PATTERN_SEQ_VOLRAMP_EN
        vol_tgt_d = vol_tgt_q;
`endif
        if (stop) begin
            state_d = IDLE;
            note_d  = '0;
            valid_d = 1'b0;
            speed_d = '0;
            row_d   = '0;
            presc_d = '0;
            tick_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (play && len != '0 && len <= LEN_MAX) begin
                        state_d = FETCH;
                        presc_d = '0;
                        tick_d  = '0;
                    end
                end
                FETCH: begin
                    load = 1'b1;
                end
                PLAY: begin
                    if (row_end) begin
                        if (last_row && !loop_en) begin
                            state_d = IDLE;
                            note_d  = '0;
                            valid_d = 1'b0;
                            speed_d = '0;
                            row_d   = '0;
                            presc_d = '0;
                            tick_d  = '0;
                            done_d  = 1'b1;
                        end else begin
                            load     = 1'b1;
                            load_row = next_row;
                        end
                    end else begin
                        presc_d = tick_end ? '0 : presc_q + PW'(1);
                        if (tick_end) begin
                            tick_d = tick_q + 4'd1;
`ifdef PATTERN_SEQ_VOLRAMP_EN
                            if (note_q[15:13] == 3'd5 && note_q[12:8] != 5'd0)
                                note_d[12:8] = note_q[12:8] - 5'd1;
                            else if (note_q[15:13] == 3'd4 && note_q[12:8] < vol_tgt_q)
                                note_d[12:8] = note_q[12:8] + 5'd1;
`endif
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
            if (load) begin
                state_d  = PLAY;
                note_d   = rdata_q;
                valid_d  = |rdata_q;
                speed_d  = calc_speed(rdata_q);
                row_d    = load_row;
                strobe_d = 1'b1;
                presc_d  = '0;
                tick_d   = '0;
`ifdef PATTERN_SEQ_VOLRAMP_EN
                vol_tgt_d = rdata_q[12:8];
                if (rdata_q[15:13] == 3'd4) note_d[12:8] = 5'd0;
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            note_q   <= '0;
            valid_q  <= 1'b0;
            speed_q  <= '0;
            row_q    <= '0;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
            presc_q  <= '0;
            tick_q   <= '0;
`ifdef PATTERN_SEQ_VOLRAMP_EN
            vol_tgt_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            note_q   <= note_d;
            valid_q  <= valid_d;
            speed_q  <= speed_d;
            row_q    <= row_d;
            strobe_q <= strobe_d;
            done_q   <= done_d;
            presc_q  <= presc_d;
            tick_q   <= tick_d;
`ifdef PATTERN_SEQ_VOLRAMP_EN
            vol_tgt_q <= vol_tgt_d;
`endif
        end
    end

    assign note_out   = note_q;
    assign note_valid = valid_q;
    assign speed      = speed_q;
    assign row        = row_q;
    assign row_strobe = strobe_q;
    assign done       = done_q;
    assign busy       = (state_q != IDLE);

endmodule
